// File: rtl/fpga_mem_arb_pkg.sv
// Shared constants and FSM state type for the FPGA-side (port B) tensor memory arbiter.
package fpga_mem_arb_pkg;

  localparam int ADDR_W_DEF    = 11;
  localparam int DATA_W_DEF    = 256;
  localparam int MAX_BURST_DEF = 16;
  localparam int BURST_W_DEF   = $clog2(MAX_BURST_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fpga_mem_rr_pick.sv
// Combinational rotating-priority picker: searches from last_i+1 (mod NUM_REQ)
// and returns the first active request as one-hot plus index.
module fpga_mem_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_o
);

  int cand;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_i) + i) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o            = 1'b1;
        grant_oh_o[cand] = 1'b1;
        grant_idx_o      = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fpga_mem_b_arbiter.sv
// Round-robin arbiter and burst sequencer for the 256-bit FPGA-side memory port:
// grants one requester at a time and expands its burst into single-beat accesses.
module fpga_mem_b_arbiter
  import fpga_mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BURST_W   = $clog2(MAX_BURST) + 1,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*BURST_W-1:0] req_burst,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_chipselect,
  output logic                       mem_write,
  output logic [DATA_W-1:0]          mem_writedata,
  output logic [DATA_W/8-1:0]        mem_byteenable,
  output logic                       mem_clken,
  input  logic [DATA_W-1:0]          mem_readdata
);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [BURST_W-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [NUM_REQ-1:0]   ready_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic [BURST_W-1:0]   win_burst;
  logic [BURST_W-1:0]   win_len;

  fpga_mem_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i       (req_valid),
    .last_i      (last_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  // Zero-length bursts still move one beat; oversized ones saturate at MAX_BURST.
  assign win_burst = req_burst[pick_idx*BURST_W +: BURST_W];
  always_comb begin
    if (win_burst == '0) begin
      win_len = BURST_W'(1);
    end else if (win_burst > BURST_W'(MAX_BURST)) begin
      win_len = BURST_W'(MAX_BURST);
    end else begin
      win_len = win_burst;
    end
  end

  // remain_q counts beats still to be issued (read) or accepted (write) after the current one.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    ready_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready_d  = pick_oh;
          owner_d  = pick_idx;
          last_d   = pick_idx;
          addr_d   = req_addr[pick_idx*ADDR_W +: ADDR_W];
          remain_d = win_len - BURST_W'(1);
          cs_d     = 1'b1;
          we_d     = req_write[pick_idx];
          if (req_write[pick_idx]) begin
            wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (remain_q != '0) begin
          addr_d   = addr_q + ADDR_W'(1);
          cs_d     = 1'b1;
          remain_d = remain_q - BURST_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (remain_q != '0) begin
          // A stalled requester leaves the address parked on the last written word.
          if (req_valid[owner_q]) begin
            ready_d[owner_q] = 1'b1;
            addr_d           = addr_q + ADDR_W'(1);
            cs_d             = 1'b1;
            we_d             = 1'b1;
            wdata_d          = req_wdata[owner_q*DATA_W +: DATA_W];
            remain_d         = remain_q - BURST_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      remain_q    <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      remain_q    <= remain_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= (cs_q && !we_q) ? (NUM_REQ'(1) << owner_q) : '0;
    end
  end

  assign req_ready      = reset ? '0 : ready_d;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = mem_readdata;
  assign busy           = (state_q != IDLE);
  assign grant_id       = owner_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

endmodule
